id_ex_pipe: RTL and testbench

//  Parametrised ID/EX pipeline register with a valid bit, hold (stall), flush (bubble insert)
//  and built-in load-use hazard detection. Sits between decode and execute. Freezes PC and
//  IF/ID via hazard_stall, and counts inserted bubbles for performance monitoring.

---
 rtl/pipeline_pkg.sv | 25 ++
 rtl/hazard_unit_lu.sv | 20 ++
 rtl/id_ex_pipe.sv | 130 +++++++++++++
 tb/tb_id_ex_pipe.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline widths, control bundle type and bubble constant
//   Exports: PIPE_* width constants, ctrl_t (ALUOp..jumpRegister), CTRL_NOP (all zeros).
package pipeline_pkg;

    localparam int PIPE_DATA_WIDTH     = 32;
    localparam int PIPE_REG_ADDR_WIDTH = 4;
    localparam int PIPE_ALUOP_WIDTH    = 5;
    localparam int PIPE_MEMTOREG_WIDTH = 2;
    localparam int PIPE_CNT_WIDTH      = 16;

    // Control fields that must be zeroed whenever a slot turns into a bubble.
    typedef struct packed {
        logic [PIPE_ALUOP_WIDTH-1:0]    alu_op;
        logic                           alu_src;
        logic                           mem_read;
        logic                           mem_write;
        logic [PIPE_MEMTOREG_WIDTH-1:0] mem_to_reg;
        logic                           reg_write;
        logic                           branch;
        logic                           jump_register;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_unit_lu.sv
// rtl/hazard_unit_lu.sv - combinational load-use hazard compare
//   In : id_valid, ex_valid, ex_mem_read, ex_rd, id_rs_a, id_rs_b
//   Out: haz - decode reads a register the load in EX has not produced yet
module hazard_unit_lu #(
    parameter int REG_ADDR_WIDTH = 4
) (
    input  logic                      id_valid,
    input  logic                      ex_valid,
    input  logic                      ex_mem_read,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs_a,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs_b,
    output logic                      haz
);

    // Full-width equality; register 0 is not treated specially.
    assign haz = id_valid & ex_valid & ex_mem_read &
                 ((ex_rd == id_rs_a) | (ex_rd == id_rs_b));

endmodule

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with stall, flush, load-use bubble and bubble counter
//   In : clock, reset (sync, active-high, falling edge), stall_in, flush_in, cnt_clear,
//        id_valid_in and the decode fields *_in
//   Out: registered fields (same names without _in), ex_valid, hazard_stall (comb), bubble_count
module id_ex_pipe
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = PIPE_DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = PIPE_REG_ADDR_WIDTH,
    parameter int ALUOP_WIDTH    = PIPE_ALUOP_WIDTH,
    parameter int MEMTOREG_WIDTH = PIPE_MEMTOREG_WIDTH,
    parameter int CNT_WIDTH      = PIPE_CNT_WIDTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      stall_in,
    input  logic                      flush_in,
    input  logic                      cnt_clear,
    input  logic                      id_valid_in,
    input  logic [DATA_WIDTH-1:0]     registerFileDataA_in,
    input  logic [DATA_WIDTH-1:0]     registerFileDataB_in,
    input  logic [REG_ADDR_WIDTH-1:0] registerFileWrite_in,
    input  logic [REG_ADDR_WIDTH-1:0] registerA_in,
    input  logic [REG_ADDR_WIDTH-1:0] registerB_in,
    input  logic [DATA_WIDTH-1:0]     pcpp_in,
    input  logic [DATA_WIDTH-1:0]     extendedSignal_in,
    input  logic [ALUOP_WIDTH-1:0]    ALUOp_in,
    input  logic                      ALUSrc_in,
    input  logic                      memRead_in,
    input  logic                      memWrite_in,
    input  logic                      regWrite_in,
    input  logic                      branch_in,
    input  logic                      jumpRegister_in,
    input  logic [MEMTOREG_WIDTH-1:0] memToReg_in,
    output logic [DATA_WIDTH-1:0]     registerFileDataA,
    output logic [DATA_WIDTH-1:0]     registerFileDataB,
    output logic [REG_ADDR_WIDTH-1:0] registerFileWrite,
    output logic [REG_ADDR_WIDTH-1:0] registerA,
    output logic [REG_ADDR_WIDTH-1:0] registerB,
    output logic [DATA_WIDTH-1:0]     pcpp,
    output logic [DATA_WIDTH-1:0]     extendedSignal,
    output logic [ALUOP_WIDTH-1:0]    ALUOp,
    output logic                      ALUSrc,
    output logic                      memRead,
    output logic                      memWrite,
    output logic                      regWrite,
    output logic                      branch,
    output logic                      jumpRegister,
    output logic [MEMTOREG_WIDTH-1:0] memToReg,
    output logic                      ex_valid,
    output logic                      hazard_stall,
    output logic [CNT_WIDTH-1:0]      bubble_count
);

    logic haz;
    logic bubble;
    logic bubble_edge;
    logic keep_ctrl;

    hazard_unit_lu #(
        .REG_ADDR_WIDTH(REG_ADDR_WIDTH)
    ) u_hazard (
        .id_valid    (id_valid_in),
        .ex_valid    (ex_valid),
        .ex_mem_read (memRead),
        .ex_rd       (registerFileWrite),
        .id_rs_a     (registerA_in),
        .id_rs_b     (registerB_in),
        .haz         (haz)
    );

    // A squashed instruction is discarded anyway, so it never needs to freeze fetch.
    assign hazard_stall = haz & ~flush_in;
    assign bubble       = flush_in | haz;
    // An external hold masks bubble insertion and its count for that edge.
    assign bubble_edge  = bubble & ~stall_in;
    // Controls survive only for a real instruction that is not being turned into a bubble.
    assign keep_ctrl    = id_valid_in & ~bubble;

    always_ff @(negedge clock) begin
        if (reset) begin
            registerFileDataA <= '0;
            registerFileDataB <= '0;
            registerFileWrite <= '0;
            registerA         <= '0;
            registerB         <= '0;
            pcpp              <= '0;
            extendedSignal    <= '0;
            ALUOp             <= '0;
            ALUSrc            <= 1'b0;
            memRead           <= 1'b0;
            memWrite          <= 1'b0;
            regWrite          <= 1'b0;
            branch            <= 1'b0;
            jumpRegister      <= 1'b0;
            memToReg          <= '0;
            ex_valid          <= 1'b0;
        end else if (!stall_in) begin
            // Data and index fields always follow the inputs; they are don't-care in a bubble.
            registerFileDataA <= registerFileDataA_in;
            registerFileDataB <= registerFileDataB_in;
            registerFileWrite <= registerFileWrite_in;
            registerA         <= registerA_in;
            registerB         <= registerB_in;
            pcpp              <= pcpp_in;
            extendedSignal    <= extendedSignal_in;
            ALUOp             <= keep_ctrl ? ALUOp_in    : '0;
            ALUSrc            <= keep_ctrl & ALUSrc_in;
            memRead           <= keep_ctrl & memRead_in;
            memWrite          <= keep_ctrl & memWrite_in;
            regWrite          <= keep_ctrl & regWrite_in;
            branch            <= keep_ctrl & branch_in;
            jumpRegister      <= keep_ctrl & jumpRegister_in;
            memToReg          <= keep_ctrl ? memToReg_in : '0;
            ex_valid          <= keep_ctrl;
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            bubble_count <= '0;
        end else if (cnt_clear) begin
            // A bubble on the clearing edge is the first one counted after the clear.
            bubble_count <= bubble_edge ? CNT_WIDTH'(1) : '0;
        end else if (bubble_edge && (bubble_count != {CNT_WIDTH{1'b1}})) begin
            bubble_count <= bubble_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - scoreboard bench for id_ex_pipe (default widths plus a 2-bit counter copy)
module tb_id_ex_pipe;

    typedef struct packed {
        logic [31:0] da;
        logic [31:0] db;
        logic [3:0]  rfw;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] pcpp;
        logic [31:0] ext;
        logic [4:0]  aluop;
        logic        alusrc;
        logic        memread;
        logic        memwrite;
        logic        regwrite;
        logic        branch;
        logic        jr;
        logic [1:0]  memtoreg;
        logic        valid;
    } pipe_t;

    typedef struct packed {
        logic  reset;
        logic  stall;
        logic  flush;
        logic  clr;
        pipe_t p;
    } in_t;

    typedef struct packed {
        pipe_t       p;
        logic [15:0] cnt;
        logic [1:0]  scnt;
    } exp_t;

    logic  clock = 1'b0;
    in_t   ui = '0;
    exp_t  exp_q[$];
    pipe_t m;
    logic [15:0] mc;
    logic [1:0]  msc;
    bit    m_init = 0;
    int    n_cmp = 0;
    int    n_bad = 0;

    pipe_t       obs;
    logic        hazard_stall;
    logic [15:0] bubble_count;
    pipe_t       s_obs;
    logic        s_hazard_stall;
    logic [1:0]  s_bubble_count;

    always #5 clock = ~clock;

    id_ex_pipe u_dut (
        .clock(clock), .reset(ui.reset), .stall_in(ui.stall), .flush_in(ui.flush),
        .cnt_clear(ui.clr), .id_valid_in(ui.p.valid),
        .registerFileDataA_in(ui.p.da), .registerFileDataB_in(ui.p.db),
        .registerFileWrite_in(ui.p.rfw), .registerA_in(ui.p.ra), .registerB_in(ui.p.rb),
        .pcpp_in(ui.p.pcpp), .extendedSignal_in(ui.p.ext), .ALUOp_in(ui.p.aluop),
        .ALUSrc_in(ui.p.alusrc), .memRead_in(ui.p.memread), .memWrite_in(ui.p.memwrite),
        .regWrite_in(ui.p.regwrite), .branch_in(ui.p.branch), .jumpRegister_in(ui.p.jr),
        .memToReg_in(ui.p.memtoreg),
        .registerFileDataA(obs.da), .registerFileDataB(obs.db), .registerFileWrite(obs.rfw),
        .registerA(obs.ra), .registerB(obs.rb), .pcpp(obs.pcpp), .extendedSignal(obs.ext),
        .ALUOp(obs.aluop), .ALUSrc(obs.alusrc), .memRead(obs.memread), .memWrite(obs.memwrite),
        .regWrite(obs.regwrite), .branch(obs.branch), .jumpRegister(obs.jr),
        .memToReg(obs.memtoreg), .ex_valid(obs.valid), .hazard_stall(hazard_stall),
        .bubble_count(bubble_count)
    );

    id_ex_pipe #(.CNT_WIDTH(2)) u_sat (
        .clock(clock), .reset(ui.reset), .stall_in(ui.stall), .flush_in(ui.flush),
        .cnt_clear(ui.clr), .id_valid_in(ui.p.valid),
        .registerFileDataA_in(ui.p.da), .registerFileDataB_in(ui.p.db),
        .registerFileWrite_in(ui.p.rfw), .registerA_in(ui.p.ra), .registerB_in(ui.p.rb),
        .pcpp_in(ui.p.pcpp), .extendedSignal_in(ui.p.ext), .ALUOp_in(ui.p.aluop),
        .ALUSrc_in(ui.p.alusrc), .memRead_in(ui.p.memread), .memWrite_in(ui.p.memwrite),
        .regWrite_in(ui.p.regwrite), .branch_in(ui.p.branch), .jumpRegister_in(ui.p.jr),
        .memToReg_in(ui.p.memtoreg),
        .registerFileDataA(s_obs.da), .registerFileDataB(s_obs.db), .registerFileWrite(s_obs.rfw),
        .registerA(s_obs.ra), .registerB(s_obs.rb), .pcpp(s_obs.pcpp), .extendedSignal(s_obs.ext),
        .ALUOp(s_obs.aluop), .ALUSrc(s_obs.alusrc), .memRead(s_obs.memread),
        .memWrite(s_obs.memwrite), .regWrite(s_obs.regwrite), .branch(s_obs.branch),
        .jumpRegister(s_obs.jr), .memToReg(s_obs.memtoreg), .ex_valid(s_obs.valid),
        .hazard_stall(s_hazard_stall), .bubble_count(s_bubble_count)
    );

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic in_t idle_in();
        in_t t;
        t = '0;
        return t;
    endfunction

    function automatic in_t rnd_in();
        in_t t;
        t.reset      = 1'b0;
        t.stall      = 1'b0;
        t.flush      = 1'b0;
        t.clr        = 1'b0;
        t.p.da       = $urandom;
        t.p.db       = $urandom;
        t.p.rfw      = 4'($urandom_range(0, 3));
        t.p.ra       = 4'($urandom_range(0, 3));
        t.p.rb       = 4'($urandom_range(0, 3));
        t.p.pcpp     = $urandom;
        t.p.ext      = $urandom;
        t.p.aluop    = 5'($urandom);
        t.p.alusrc   = 1'($urandom);
        t.p.memread  = 1'($urandom);
        t.p.memwrite = 1'($urandom);
        t.p.regwrite = 1'($urandom);
        t.p.branch   = 1'($urandom);
        t.p.jr       = 1'($urandom);
        t.p.memtoreg = 2'($urandom);
        t.p.valid    = ($urandom_range(0, 4) != 0);
        return t;
    endfunction

    // Drive one falling edge: apply inputs after a rising edge, check the combinational
    // stall, push the model's expectation, then compare just after the falling edge.
    task automatic step(input in_t t, input string tag);
        logic  haz;
        logic  bub;
        pipe_t n;
        exp_t  e;
        @(posedge clock);
        ui = t;
        #1;
        haz = t.p.valid & m.valid & m.memread & ((m.rfw == t.p.ra) | (m.rfw == t.p.rb));
        if (m_init) check({tag, ".hazard_stall"}, 160'(hazard_stall), 160'(haz & ~t.flush));
        bub = ~t.stall & (t.flush | haz);
        if (t.reset) begin
            m = '0; mc = '0; msc = '0;
        end else begin
            if (!t.stall) begin
                n = t.p;
                if (bub || !t.p.valid) begin
                    n.aluop = '0; n.alusrc = 0; n.memread = 0; n.memwrite = 0;
                    n.regwrite = 0; n.branch = 0; n.jr = 0; n.memtoreg = '0; n.valid = 0;
                end
                m = n;
            end
            if (t.clr) begin
                mc = 16'(bub); msc = 2'(bub);
            end else if (bub) begin
                if (mc != 16'hffff) mc = mc + 16'd1;
                if (msc != 2'd3) msc = msc + 2'd1;
            end
        end
        m_init = 1;
        e.p = m; e.cnt = mc; e.scnt = msc;
        exp_q.push_back(e);
        @(negedge clock);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 160'(0), 160'(1));
        end else begin
            e = exp_q.pop_front();
            check({tag, ".fields"}, 160'(obs), 160'(e.p));
            check({tag, ".bubble_count"}, 160'(bubble_count), 160'(e.cnt));
            check({tag, ".sat_count"}, 160'(s_bubble_count), 160'(e.scnt));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        in_t t;
        in_t t2;
        m = '0; mc = '0; msc = '0;

        // Reset with arbitrary inputs
        t = rnd_in(); t.reset = 1; t.flush = 1; step(t, "reset");
        check("reset.ex_valid", 160'(obs.valid), 160'(0));
        check("reset.count", 160'(bubble_count), 160'(0));

        // Plain load
        t = idle_in(); t.p.da = 32'h12345678; t.p.aluop = 5'h3; t.p.regwrite = 1; t.p.valid = 1;
        step(t, "load");
        check("load.dataA", 160'(obs.da), 160'(32'h12345678));

        // Load-use hazard then release
        t = idle_in(); t.p.valid = 1; t.p.memread = 1; t.p.rfw = 4'h7; t.p.ra = 1; t.p.rb = 2;
        step(t, "lu.load");
        t2 = idle_in(); t2.p.valid = 1; t2.p.ra = 3; t2.p.rb = 4'h7; t2.p.aluop = 5'h2;
        t2.p.regwrite = 1; t2.p.rfw = 4'h8;
        step(t2, "lu.bubble");
        check("lu.bubble.ex_valid", 160'(obs.valid), 160'(0));
        check("lu.bubble.count", 160'(bubble_count), 160'(1));
        step(t2, "lu.reload");
        check("lu.reload.ex_valid", 160'(obs.valid), 160'(1));

        // Hazard coinciding with flush counts once
        step(t, "luf.load");
        t2.flush = 1;
        step(t2, "luf.flush");
        check("luf.count", 160'(bubble_count), 160'(2));

        // Stall ignores flush until it drops
        t = rnd_in(); t.p.valid = 1; step(t, "stall.pre");
        for (int k = 0; k < 3; k++) begin
            t = rnd_in(); t.stall = 1; t.flush = 1; step(t, "stall.hold");
        end
        t = rnd_in(); t.flush = 1; step(t, "stall.drop");

        // Reset wins over stall
        t = rnd_in(); t.stall = 1; t.reset = 1; step(t, "reset_stall");

        // Saturation of the 2-bit counter and clear
        for (int k = 0; k < 5; k++) begin
            t = rnd_in(); t.flush = 1; step(t, "sat.flush");
        end
        check("sat.value", 160'(s_bubble_count), 160'(3));
        t = idle_in(); t.clr = 1; step(t, "sat.clear");
        check("sat.cleared", 160'(s_bubble_count), 160'(0));
        t = idle_in(); t.clr = 1; t.flush = 1; step(t, "sat.clear_bubble");

        // Random traffic
        for (int k = 0; k < 60; k++) begin
            t = rnd_in();
            t.stall = ($urandom_range(0, 4) == 0);
            t.flush = ($urandom_range(0, 5) == 0);
            t.clr   = ($urandom_range(0, 9) == 0);
            t.reset = ($urandom_range(0, 29) == 0);
            step(t, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
